// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: request encodings,
// byte-lane indices, the write-buffer entry and a per-byte merge helper.
package dmem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Bit index within mask (and byte index within a word) of each memory byte offset.
  localparam int LANE_OFF0 = 3;
  localparam int LANE_OFF1 = 2;
  localparam int LANE_OFF2 = 1;
  localparam int LANE_OFF3 = 0;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wbuf_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] over,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = base;
    for (int i = LANE_OFF3; i <= LANE_OFF0; i++) begin
      if (sel[i]) r[8*i +: 8] = over[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with synchronous byte-enable write and a registered,
// read-enabled output that holds between reads. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = LANE_OFF3; i <= LANE_OFF0; i++) begin
        if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read-before-write on a same-edge collision; the top covers that with its bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: one-entry write buffer, per-byte read bypass and an
// optional sticky out-of-range fault, enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        clk_en,
  input  logic        bus_lock,
  input  logic        memory_mode,
  input  logic [29:0] address_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  mask,
  output logic [31:0] rdata_out,
  output logic        rvalid_out,
  output logic        fault_out,
  output logic [29:0] fault_addr_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  wbuf_entry_t wbuf;
  logic        req_acc;
  logic        rd_acc;
  logic        wr_acc;
  logic        oob;
  logic        hit;
  logic [31:0] arr_q;
  logic [31:0] byp_data;
  logic [3:0]  byp_mask;
  logic        rd_zero;
  logic        unused_addr_hi;

  assign req_acc = bus_lock && clk_en;
  assign rd_acc  = req_acc && (memory_mode == MEM_READ);
  assign wr_acc  = req_acc && (memory_mode == MEM_WRITE);
  assign hit     = wbuf.valid && (wbuf.addr[AW-1:0] == address_in[AW-1:0]);

  // Upper buffered address bits only matter for aliasing, which the index compare already covers.
  assign unused_addr_hi = ^wbuf.addr;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = (address_in >= 30'(DEPTH_WORDS));

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      fault_out      <= 1'b0;
      fault_addr_out <= '0;
    end else if (req_acc && oob && !fault_out) begin
      fault_out      <= 1'b1;
      fault_addr_out <= address_in;
    end
  end
`else
  assign oob            = 1'b0;
  assign fault_out      = 1'b0;
  assign fault_addr_out = '0;
`endif

  // The buffer commits on the edge after capture whatever clk_en does; reset drops it.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wbuf.valid <= 1'b0;
    end else if (wr_acc && !oob) begin
      wbuf <= '{valid: 1'b1, addr: address_in, data: data_in, mask: mask};
    end else begin
      wbuf.valid <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (sync_rst),
    .we    (wbuf.valid && !sync_rst),
    .waddr (wbuf.addr[AW-1:0]),
    .wdata (wbuf.data),
    .wmask (wbuf.mask),
    .re    (rd_acc),
    .raddr (address_in[AW-1:0]),
    .rdata (arr_q)
  );

  // Bypass bytes are latched alongside the array read so rdata_out holds until the next read.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rvalid_out <= 1'b0;
      byp_mask   <= '0;
      byp_data   <= '0;
      rd_zero    <= 1'b0;
    end else begin
      rvalid_out <= rd_acc;
      if (rd_acc) begin
        byp_mask <= hit ? wbuf.mask : 4'b0000;
        byp_data <= wbuf.data;
        rd_zero  <= oob;
      end
    end
  end

  assign rdata_out = rd_zero ? 32'h0 : merge_bytes(arr_q, byp_data, byp_mask);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS = 1024).
module tb_data_mem_responder;

  logic        clk;
  logic        sync_rst;
  logic        clk_en;
  logic        bus_lock;
  logic        memory_mode;
  logic [29:0] address_in;
  logic [31:0] data_in;
  logic [3:0]  mask;
  logic [31:0] rdata_out;
  logic        rvalid_out;
  logic        fault_out;
  logic [29:0] fault_addr_out;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk            (clk),
    .sync_rst       (sync_rst),
    .clk_en         (clk_en),
    .bus_lock       (bus_lock),
    .memory_mode    (memory_mode),
    .address_in     (address_in),
    .data_in        (data_in),
    .mask           (mask),
    .rdata_out      (rdata_out),
    .rvalid_out     (rvalid_out),
    .fault_out      (fault_out),
    .fault_addr_out (fault_addr_out)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_lock = 1'b0;
    clk_en   = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_lock = 1'b1; clk_en = 1'b1; memory_mode = 1'b1;
    address_in = a; data_in = d; mask = m;
    step();
    bus_lock = 1'b0;
  endtask

  task automatic issue_read(input logic [29:0] a);
    bus_lock = 1'b1; clk_en = 1'b1; memory_mode = 1'b0;
    address_in = a; mask = 4'b1111; data_in = 32'hDEAD_BEEF;
    step();
    bus_lock = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1; bus_lock = 1'b0; clk_en = 1'b0; memory_mode = 1'b0;
    address_in = '0; data_in = '0; mask = '0;
    step(); step();
    sync_rst = 1'b0;
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata_out, 32'h0); end
    checks++; if (rvalid_out !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid_out); end
    checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_out); end
    checks++; if (fault_addr_out !== 30'h0) begin errors++; $display("FAIL reset_fault_addr: got %h expected 0", fault_addr_out); end
  endtask

  task automatic test_basic_rw();
    issue_write(30'd5, 32'h1122_3344, 4'b1111);
    idle(2);
    issue_read(30'd5);
    checks++; if (rvalid_out !== 1'b1) begin errors++; $display("FAIL basic_rvalid: got %b expected 1", rvalid_out); end
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL basic_rdata: got %h expected %h", rdata_out, 32'h1122_3344); end
    idle(1);
    checks++; if (rvalid_out !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", rvalid_out); end
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL basic_hold: got %h expected %h", rdata_out, 32'h1122_3344); end
  endtask

  task automatic test_bypass();
    issue_write(30'd7, 32'hAABB_CCDD, 4'b1111);
    idle(1);
    issue_write(30'd7, 32'h0000_5500, 4'b0010);
    issue_read(30'd7);
    checks++; if (rdata_out !== 32'hAABB_55DD) begin errors++; $display("FAIL bypass_rdata: got %h expected %h", rdata_out, 32'hAABB_55DD); end
    idle(1);
    issue_read(30'd7);
    checks++; if (rdata_out !== 32'hAABB_55DD) begin errors++; $display("FAIL bypass_commit: got %h expected %h", rdata_out, 32'hAABB_55DD); end
  endtask

  task automatic test_back_to_back();
    issue_write(30'd3, 32'h3344_5566, 4'b1111);
    idle(1);
    issue_write(30'd2, 32'h0101_0101, 4'b1111);
    issue_write(30'd3, 32'h0202_0202, 4'b1000);
    issue_read(30'd2);
    checks++; if (rdata_out !== 32'h0101_0101) begin errors++; $display("FAIL b2b_word2: got %h expected %h", rdata_out, 32'h0101_0101); end
    issue_read(30'd3);
    checks++; if (rdata_out !== 32'h0244_5566) begin errors++; $display("FAIL b2b_word3: got %h expected %h", rdata_out, 32'h0244_5566); end
  endtask

  task automatic test_mask_zero();
    issue_write(30'd5, 32'hFFFF_FFFF, 4'b0000);
    issue_read(30'd5);
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL mask0_bypass: got %h expected %h", rdata_out, 32'h1122_3344); end
    idle(1);
    issue_read(30'd5);
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL mask0_array: got %h expected %h", rdata_out, 32'h1122_3344); end
  endtask

  task automatic test_other_word();
    issue_write(30'd10, 32'h1234_5678, 4'b1111);
    idle(1);
    issue_write(30'd10, 32'h9ABC_DEF0, 4'b1111);
    issue_read(30'd5);
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL other_word: got %h expected %h", rdata_out, 32'h1122_3344); end
    issue_read(30'd10);
    checks++; if (rdata_out !== 32'h9ABC_DEF0) begin errors++; $display("FAIL other_commit: got %h expected %h", rdata_out, 32'h9ABC_DEF0); end
  endtask

  task automatic test_clk_en();
    bus_lock = 1'b1; clk_en = 1'b0; memory_mode = 1'b0; address_in = 30'd5;
    step();
    checks++; if (rvalid_out !== 1'b0) begin errors++; $display("FAIL clken_rvalid: got %b expected 0", rvalid_out); end
    checks++; if (rdata_out !== 32'h9ABC_DEF0) begin errors++; $display("FAIL clken_hold: got %h expected %h", rdata_out, 32'h9ABC_DEF0); end
    memory_mode = 1'b1; address_in = 30'd10; data_in = 32'h0; mask = 4'b1111;
    step();
    idle(1);
    issue_read(30'd10);
    checks++; if (rdata_out !== 32'h9ABC_DEF0) begin errors++; $display("FAIL clken_write: got %h expected %h", rdata_out, 32'h9ABC_DEF0); end
  endtask

  task automatic test_reset_discard();
    issue_write(30'd9, 32'h9999_9999, 4'b1111);
    idle(1);
    issue_write(30'd9, 32'h1212_1212, 4'b1111);
    // Reset cycle also carries a write request, which reset must override.
    sync_rst = 1'b1; bus_lock = 1'b1; clk_en = 1'b1; memory_mode = 1'b1;
    address_in = 30'd9; data_in = 32'h5555_5555; mask = 4'b1111;
    step();
    sync_rst = 1'b0; bus_lock = 1'b0;
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata_out); end
    checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fault_out); end
    idle(1);
    issue_read(30'd9);
    checks++; if (rdata_out !== 32'h9999_9999) begin errors++; $display("FAIL rst_discard: got %h expected %h", rdata_out, 32'h9999_9999); end
  endtask

  task automatic test_bounds();
    issue_write(30'd0, 32'h0BAD_F00D, 4'b1111);
    issue_write(30'd976, 32'h0000_7D0A, 4'b1111);
    idle(1);
    issue_read(30'd1024);
    checks++; if (rvalid_out !== 1'b1) begin errors++; $display("FAIL oob_rvalid: got %b expected 1", rvalid_out); end
`ifdef DMEM_BOUNDS_CHECK_EN
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL oob_rdata: got %h expected 0", rdata_out); end
    checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL oob_fault: got %b expected 1", fault_out); end
    checks++; if (fault_addr_out !== 30'd1024) begin errors++; $display("FAIL oob_fault_addr: got %0d expected 1024", fault_addr_out); end
    issue_write(30'd1029, 32'hFFFF_FFFF, 4'b1111);
    idle(1);
    issue_read(30'd2000);
    checks++; if (fault_addr_out !== 30'd1024) begin errors++; $display("FAIL oob_first_only: got %0d expected 1024", fault_addr_out); end
    issue_read(30'd5);
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL oob_no_write: got %h expected %h", rdata_out, 32'h1122_3344); end
    checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b expected 1", fault_out); end
`else
    checks++; if (rdata_out !== 32'h0BAD_F00D) begin errors++; $display("FAIL wrap_rdata: got %h expected %h", rdata_out, 32'h0BAD_F00D); end
    issue_read(30'd2000);
    checks++; if (rdata_out !== 32'h0000_7D0A) begin errors++; $display("FAIL wrap_2000: got %h expected %h", rdata_out, 32'h0000_7D0A); end
    checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL wrap_fault: got %b expected 0", fault_out); end
    checks++; if (fault_addr_out !== 30'd0) begin errors++; $display("FAIL wrap_fault_addr: got %0d expected 0", fault_addr_out); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_bypass();
    test_back_to_back();
    test_mask_zero();
    test_other_word();
    test_clk_en();
    test_reset_discard();
    test_bounds();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 sync_rst  input  1  reset, synchronous, active-high.
REQ-004 clk_en  input  1  pipeline advance; a request SHALL be accepted only when clk_en=1.
REQ-005 bus_lock  input  1  memory request valid this cycle.
REQ-006 memory_mode  input  1  0 = read (load), 1 = write (store).
REQ-007 address_in  input  30  word address.
REQ-008 data_in  input  32  store data in memory lane order; [31:24] = byte offset 0, [7:0] = byte offset 3.
REQ-009 mask  input  4  byte write enables; mask[3] = offset 0, mask[0] = offset 3.
REQ-010 rdata_out  output  32  load data word, same lane order as data_in, unaligned and unextended.
REQ-011 rvalid_out  output  1  one-cycle pulse marking new rdata_out.
REQ-012 fault_out  output  1  sticky out-of-range access flag (see Configuration).
REQ-013 fault_addr_out  output  30  word address of the first faulting access.

Function
REQ-014 Accepted request = bus_lock && clk_en in cycle N; otherwise inputs SHALL be ignored.
REQ-015 Accepted read: rdata_out SHALL present the full addressed word at cycle N+1 with rvalid_out=1 for exactly that cycle; mask is ignored on reads.
REQ-016 rdata_out SHALL hold its value until the next accepted read.
REQ-017 Accepted write: address, data_in and mask SHALL be captured into a one-entry write buffer at the edge ending cycle N.
REQ-018 A valid buffer entry SHALL commit its masked bytes to the array at the next edge, independent of clk_en; unmasked bytes SHALL remain unchanged.
REQ-019 Write with mask=4'b0000 SHALL modify no array byte.
REQ-020 A write accepted while the buffer is valid: the old entry SHALL commit and the new one be captured at the same edge; no write is lost.
REQ-021 A read accepted while the buffer holds the same word address: each byte with buffered mask bit set SHALL come from the buffer, every other byte from the array (per-byte bypass).
REQ-022 A read to a different word while the buffer is valid SHALL return array contents unaffected by the pending write.
REQ-023 Array index = address_in[log2(DEPTH_WORDS)-1:0].

Reset
REQ-024 sync_rst SHALL clear rdata_out to 0, rvalid_out to 0, the buffer valid flag, fault_out to 0 and fault_addr_out to 0.
REQ-025 A buffer entry pending at reset SHALL be discarded, not committed.
REQ-026 Array contents SHALL NOT be reset; sync_rst SHALL take priority over any request in the same cycle.

Configuration
REQ-027 Macro DMEM_BOUNDS_CHECK_EN defined: an accepted access with address_in >= DEPTH_WORDS SHALL not enter the buffer (write) or SHALL return 0 with rvalid_out=1 (read); fault_out SHALL set at N+1 and stay set until reset; fault_addr_out SHALL capture the first faulting address only.
REQ-028 Macro undefined: addresses SHALL wrap per REQ-023; fault_out and fault_addr_out SHALL be tied to 0.

Structure
REQ-029 Shared package dmem_pkg SHALL hold MEM_READ/MEM_WRITE encodings, lane-index constants and a write-buffer entry struct (valid, addr, data, mask).
REQ-030 Storage SHALL be a sub-module dmem_array (synchronous byte-enable write, registered read); buffer, bypass and fault logic SHALL be in the top.

Verification
REQ-031 Write 0x11223344 mask 1111 to addr 5, idle 2 cycles, read addr 5 -> rdata_out=0x11223344, rvalid_out one cycle later.
REQ-032 Word 7 = 0xAABBCCDD; write 0x00005500 mask 0010 to 7, read 7 the next cycle -> 0xAABB55DD (bypass).
REQ-033 Back-to-back writes: 0x01010101 mask 1111 to addr 2, then 0x02020202 mask 1000 to addr 3, then reads of 2 and 3 -> 0x01010101, 0x02xxxxxx with lower three bytes unchanged.
REQ-034 Read with clk_en=0 and bus_lock=1 -> no rvalid_out, rdata_out unchanged.
REQ-035 Write to addr 9, sync_rst asserted next cycle, then read 9 -> old contents; rdata_out=0 and fault_out=0 just after reset.
REQ-036 With DMEM_BOUNDS_CHECK_EN, DEPTH_WORDS=1024: read addr 1024 -> rdata_out=0, fault_out=1, fault_addr_out=1024; later fault at 2000 leaves fault_addr_out=1024; without macro, same read returns word 0.
